// File: rtl/templatized_alu_pkg.sv
// -----------------------------------------------------------------------------
// templatized_alu_pkg
//
// Shared definitions for the ALU issue stage and its FIFO:
//   - opcode constants for the XOR and shift/rotate groups
//   - alu_op_t : {op_code, a, b} at the default operand width
//   - issue_state_e : issue FSM states
//   - helpers to classify an opcode
//
// No ports (package).
// -----------------------------------------------------------------------------
package templatized_alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;  // default operand width
    localparam int unsigned OP_W      = 3;   // opcode width

    localparam logic [OP_W-1:0] OPCODE_XOR           = 3'd0;
    localparam logic [OP_W-1:0] OPCODE_SLL           = 3'd1;
    localparam logic [OP_W-1:0] OPCODE_SAR           = 3'd2;
    localparam logic [OP_W-1:0] OPCODE_ROTATIONLEFT  = 3'd3;
    localparam logic [OP_W-1:0] OPCODE_ROTATIONRIGHT = 3'd4;

    // One queued operation at the default width. Modules with a different
    // WIDTH declare the same layout locally with their own operand width.
    typedef struct packed {
        logic [OP_W-1:0]      op_code;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } issue_state_e;

    // Opcodes 5..7 have no datapath behind them and are dropped at the input.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op_code);
        return op_code <= OPCODE_ROTATIONRIGHT;
    endfunction

    // XOR completes in one cycle; everything else is a shift/rotate.
    function automatic logic is_xor_group(input logic [OP_W-1:0] op_code);
        return op_code == OPCODE_XOR;
    endfunction

endpackage

// File: rtl/templatized_alu_issue_fifo.sv
// -----------------------------------------------------------------------------
// templatized_alu_issue_fifo
//
// Synchronous FIFO for queued ALU operations. Head entry is presented
// combinationally on rd_data whenever the FIFO is non-empty. Pushes while
// full and pops while empty are ignored. An occupancy counter drives
// full/empty so neither depends on same-cycle push/pop.
//
// Parameters:
//   DATA_W : entry width in bits
//   DEPTH  : number of entries, power of two, >= 2
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (pointers and count)
//   push     in   write wr_data this cycle
//   wr_data  in   DATA_W entry to write
//   pop      in   discard the head entry this cycle
//   rd_data  out  DATA_W head entry
//   full     out  DEPTH entries held
//   empty    out  no entries held
// -----------------------------------------------------------------------------
module templatized_alu_issue_fifo #(
    parameter int unsigned DATA_W = 67,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic push_en;
    logic pop_en;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rd_data = mem[rd_ptr_q];

    // NOTE: the storage array has no reset; entries are only observed once
    // the count says they were written, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/templatized_alu_issue.sv
// -----------------------------------------------------------------------------
// templatized_alu_issue
//
// Issue stage in front of the ALU control decoder and datapath. Accepts ops
// over valid/ready, queues them, and holds one op at a time in the issue
// register for its group latency (1 cycle for XOR, SHIFT_LAT cycles for
// shift/rotate). Illegal opcodes are accepted, dropped, and flagged.
//
// Optional feature: define TEMPLATIZED_ALU_ISSUE_STATS_EN to add the
// saturating issued_count port.
//
// Parameters:
//   WIDTH     : operand width
//   DEPTH     : FIFO entries, power of two, >= 2
//   SHIFT_LAT : cycles a shift/rotate op is held, >= 1
//
// Ports:
//   clk           in   clock
//   rst_n         in   synchronous active-low reset
//   in_valid      in   upstream op valid
//   in_ready      out  stage can accept an op (registered, = !full)
//   in_op_code    in   3-bit opcode
//   in_a, in_b    in   WIDTH operands
//   alu_valid     out  issue register holds a live op
//   alu_op_code   out  opcode to the control decoder
//   alu_a, alu_b  out  operands to the datapath
//   alu_retire    out  pulse on the final cycle of an op
//   illegal       out  pulse the cycle after an illegal-opcode handshake
//   issued_count  out  16-bit saturating retire count (stats build only)
// -----------------------------------------------------------------------------
module templatized_alu_issue
    import templatized_alu_pkg::*;
#(
    parameter int unsigned WIDTH     = ALU_WIDTH,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SHIFT_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op_code,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             alu_valid,
    output logic [2:0]       alu_op_code,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_retire,
    output logic             illegal
`ifdef TEMPLATIZED_ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]      issued_count
`endif
);

    // Same layout as alu_op_t, sized by this instance's WIDTH.
    typedef struct packed {
        logic [OP_W-1:0]  op_code;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);
    // Counter must hold SHIFT_LAT-1; keep at least one bit when SHIFT_LAT is 1.
    localparam int unsigned LAT_W   = (SHIFT_LAT > 1) ? $clog2(SHIFT_LAT) : 1;

    function automatic logic [LAT_W-1:0] lat_load(input logic [OP_W-1:0] op_code);
        return is_xor_group(op_code) ? '0 : LAT_W'(SHIFT_LAT - 1);
    endfunction

    // ---------------------------------------------------------------- input
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;
    logic   in_fire;
    logic   push;
    entry_t wr_entry;
    entry_t head;
    logic [ENTRY_W-1:0] head_raw;

    assign in_ready = !fifo_full;
    assign in_fire  = in_valid && in_ready;
    assign push     = in_fire && is_legal_op(in_op_code);
    assign wr_entry = '{op_code: in_op_code, a: in_a, b: in_b};
    assign head     = entry_t'(head_raw);

    templatized_alu_issue_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (head_raw),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ------------------------------------------------------------------ FSM
    issue_state_e     state_q;
    issue_state_e     state_d;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [LAT_W-1:0] lat_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = EXEC;
                    lat_cnt_d = lat_load(head.op_code);
                end
            end
            EXEC: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end else if (!fifo_empty) begin
                    // Retiring with work queued: reload on the same edge.
                    lat_cnt_d = lat_load(head.op_code);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_valid  = 1'b0;
        alu_retire = 1'b0;
        fifo_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                fifo_pop = !fifo_empty;
            end
            EXEC: begin
                alu_valid  = 1'b1;
                alu_retire = (lat_cnt_q == '0);
                fifo_pop   = (lat_cnt_q == '0) && !fifo_empty;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------- issue register
    // Loads only on a pop, so it is stable through an op and keeps its last
    // value while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_op_code <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
        end else if (fifo_pop) begin
            alu_op_code <= head.op_code;
            alu_a       <= head.a;
            alu_b       <= head.b;
        end
    end

    // -------------------------------------------------------- illegal pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else begin
            illegal <= in_fire && !is_legal_op(in_op_code);
        end
    end

`ifdef TEMPLATIZED_ALU_ISSUE_STATS_EN
    // ---------------------------------------------------- retire statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_count <= '0;
        end else if (alu_retire && (issued_count != 16'hFFFF)) begin
            issued_count <= issued_count + 16'd1;
        end
    end
`endif

endmodule
